// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing and test-pattern generator (colour bars / grid) driven by the 2-bit PIO control word.
// Optional: define VGA_TIMING_BORDER_EN to add a 1-pixel white border over either pattern.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] ctrl,
  output logic       vga_hs_n,
  output logic       vga_vs_n,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       blank_n,
  output logic       frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_S = H_ACTIVE + H_FP;
  localparam int H_SYNC_E = H_SYNC_S + H_SYNC - 1;
  localparam int V_SYNC_S = V_ACTIVE + V_FP;
  localparam int V_SYNC_E = V_SYNC_S + V_SYNC - 1;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BAR_W    = H_ACTIVE / 8;

  logic [DW-1:0] r_div;
  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          r_pat;

  logic          w_pix_en;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_origin;
  logic          w_pat_sel;
  logic          w_active;
  logic          w_hs_on;
  logic          w_vs_on;
  logic          w_grid_on;
  logic [2:0]    w_bar;
  logic [11:0]   w_bars_rgb;
  logic [11:0]   w_rgb;

  assign w_pix_en = ctrl[0] && (r_div == DW'(CLK_DIV - 1));
  assign w_h_last = (r_h_cnt == HW'(H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == VW'(V_TOTAL - 1));
  assign w_origin = (r_h_cnt == '0) && (r_v_cnt == '0);

  // The (0,0) pixel already uses the newly latched pattern, so a frame is never mixed.
  assign w_pat_sel = w_origin ? ctrl[1] : r_pat;

  assign w_active = (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));
  assign w_hs_on  = (r_h_cnt >= HW'(H_SYNC_S)) && (r_h_cnt <= HW'(H_SYNC_E));
  assign w_vs_on  = (r_v_cnt >= VW'(V_SYNC_S)) && (r_v_cnt <= VW'(V_SYNC_E));
  assign w_grid_on = ((32'(r_h_cnt) & 32'h1F) == 32'd0) || ((32'(r_v_cnt) & 32'h1F) == 32'd0);

  // Bar index by comparator chain: the last (smallest) matching threshold wins.
  always_comb begin
    w_bar = 3'd7;
    for (int unsigned k = 0; k < 8; k++) begin
      if (32'(r_h_cnt) < (8 - k) * BAR_W) begin
        w_bar = 3'(7 - k);
      end
    end
  end

  assign w_bars_rgb = {{4{~w_bar[1]}}, {4{~w_bar[2]}}, {4{~w_bar[0]}}};

  always_comb begin
    w_rgb = '0;
    if (w_active) begin
      w_rgb = w_pat_sel ? (w_grid_on ? 12'hFFF : 12'h000) : w_bars_rgb;
`ifdef VGA_TIMING_BORDER_EN
      if ((r_h_cnt == '0) || (r_h_cnt == HW'(H_ACTIVE - 1)) ||
          (r_v_cnt == '0) || (r_v_cnt == VW'(V_ACTIVE - 1))) begin
        w_rgb = 12'hFFF;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div       <= '0;
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_pat       <= 1'b0;
      vga_hs_n    <= 1'b1;
      vga_vs_n    <= 1'b1;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      blank_n     <= 1'b0;
      frame_start <= 1'b0;
    end else if (!ctrl[0]) begin
      r_div       <= '0;
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      vga_hs_n    <= 1'b1;
      vga_vs_n    <= 1'b1;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      blank_n     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (w_pix_en) begin
        r_div <= '0;
        if (w_h_last) begin
          r_h_cnt <= '0;
          r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
        end else begin
          r_h_cnt <= r_h_cnt + 1'b1;
        end
        if (w_origin) begin
          r_pat <= ctrl[1];
        end
        vga_hs_n    <= ~w_hs_on;
        vga_vs_n    <= ~w_vs_on;
        vga_r       <= w_rgb[11:8];
        vga_g       <= w_rgb[7:4];
        vga_b       <= w_rgb[3:0];
        blank_n     <= w_active;
        frame_start <= w_origin;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen; vertical timing is shortened (8-line frame) to keep runs short,
// horizontal timing and bar geometry are the 640-pixel defaults.
module tb_vga_timing_gen;

  localparam int CLK_DIV  = 2;
  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
`ifdef VGA_TIMING_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] ctrl;
  logic       vga_hs_n, vga_vs_n, blank_n, frame_start;
  logic [3:0] vga_r, vga_g, vga_b;

  int n_tests = 0;
  int n_fail  = 0;
  int pos     = 0;

  typedef struct {
    int         x;
    int         y;
    logic [11:0] rgb;
    logic       blank;
    logic       hs;
    logic       vs;
  } vec_t;

  vec_t bars[$];
  vec_t grid[$];

  always #10 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(H_ACTIVE),
    .H_FP    (16),
    .H_SYNC  (96),
    .H_BP    (48),
    .V_ACTIVE(V_ACTIVE),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ctrl       (ctrl),
    .vga_hs_n   (vga_hs_n),
    .vga_vs_n   (vga_vs_n),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .blank_n    (blank_n),
    .frame_start(frame_start)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic sig(input bit use_vs);
    return use_vs ? vga_vs_n : vga_hs_n;
  endfunction

  // pos counts negedges since the one where frame_start was seen; pixel (x,y) shows at 2*(y*800+x).
  task automatic goto(input int x, input int y);
    int off;
    off = CLK_DIV * (y * H_TOTAL + x);
    if (off < pos) begin
      n_tests++;
      n_fail++;
      $display("FAIL goto: target offset %0d behind position %0d", off, pos);
    end
    while (pos < off) begin
      @(negedge clk);
      pos++;
    end
  endtask

  task automatic wait_fs();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (frame_start !== 1'b1 && k < 20000);
    chk("frame_start_seen", 32'(frame_start), 32'd1);
    pos = 0;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    logic [11:0] exp_rgb;
    exp_rgb = v.rgb;
    if (BORDER && v.blank &&
        (v.x == 0 || v.x == H_ACTIVE - 1 || v.y == 0 || v.y == V_ACTIVE - 1)) begin
      exp_rgb = 12'hFFF;
    end
    goto(v.x, v.y);
    chk($sformatf("%s rgb(%0d,%0d)", tag, v.x, v.y), 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
    chk($sformatf("%s blank_n(%0d,%0d)", tag, v.x, v.y), 32'(blank_n), 32'(v.blank));
    chk($sformatf("%s hs_n(%0d,%0d)", tag, v.x, v.y), 32'(vga_hs_n), 32'(v.hs));
    chk($sformatf("%s vs_n(%0d,%0d)", tag, v.x, v.y), 32'(vga_vs_n), 32'(v.vs));
  endtask

  task automatic measure(input bit use_vs, input int bound, output int low, output int per);
    int  k;
    logic prev, cur;
    bit  fell;
    low  = 0;
    per  = 0;
    k    = 0;
    fell = 1'b0;
    prev = sig(use_vs);
    while (!fell && k < bound) begin
      @(negedge clk);
      k++;
      cur  = sig(use_vs);
      fell = prev && !cur;
      prev = cur;
    end
    if (fell) begin
      low = 1;
      while (per < bound) begin
        @(negedge clk);
        per++;
        cur = sig(use_vs);
        if (prev && !cur) break;
        if (!cur) low++;
        prev = cur;
      end
    end
  endtask

  initial begin
    int lo, per;
    reset_n = 1'b0;
    ctrl    = 2'b00;

    bars.push_back('{0,   0, 12'hFFF, 1'b1, 1'b1, 1'b1});
    bars.push_back('{79,  0, 12'hFFF, 1'b1, 1'b1, 1'b1});
    bars.push_back('{80,  0, 12'hFF0, 1'b1, 1'b1, 1'b1});
    bars.push_back('{159, 0, 12'hFF0, 1'b1, 1'b1, 1'b1});
    bars.push_back('{160, 0, 12'h0FF, 1'b1, 1'b1, 1'b1});
    bars.push_back('{240, 0, 12'h0F0, 1'b1, 1'b1, 1'b1});
    bars.push_back('{320, 0, 12'hF0F, 1'b1, 1'b1, 1'b1});
    bars.push_back('{400, 0, 12'hF00, 1'b1, 1'b1, 1'b1});
    bars.push_back('{480, 0, 12'h00F, 1'b1, 1'b1, 1'b1});
    bars.push_back('{560, 0, 12'h000, 1'b1, 1'b1, 1'b1});
    bars.push_back('{639, 0, 12'h000, 1'b1, 1'b1, 1'b1});
    bars.push_back('{640, 0, 12'h000, 1'b0, 1'b1, 1'b1});
    bars.push_back('{655, 0, 12'h000, 1'b0, 1'b1, 1'b1});
    bars.push_back('{656, 0, 12'h000, 1'b0, 1'b0, 1'b1});
    bars.push_back('{751, 0, 12'h000, 1'b0, 1'b0, 1'b1});
    bars.push_back('{752, 0, 12'h000, 1'b0, 1'b1, 1'b1});
    bars.push_back('{799, 0, 12'h000, 1'b0, 1'b1, 1'b1});
    bars.push_back('{240, 2, 12'h0F0, 1'b1, 1'b1, 1'b1});
    bars.push_back('{100, 3, 12'hFF0, 1'b1, 1'b1, 1'b1});
    bars.push_back('{100, 4, 12'h000, 1'b0, 1'b1, 1'b1});
    bars.push_back('{0,   5, 12'h000, 1'b0, 1'b1, 1'b0});
    bars.push_back('{700, 6, 12'h000, 1'b0, 1'b0, 1'b0});
    bars.push_back('{799, 6, 12'h000, 1'b0, 1'b1, 1'b0});
    bars.push_back('{0,   7, 12'h000, 1'b0, 1'b1, 1'b1});

    grid.push_back('{0,   0, 12'hFFF, 1'b1, 1'b1, 1'b1});
    grid.push_back('{1,   0, 12'hFFF, 1'b1, 1'b1, 1'b1});
    grid.push_back('{639, 0, 12'hFFF, 1'b1, 1'b1, 1'b1});
    grid.push_back('{640, 0, 12'h000, 1'b0, 1'b1, 1'b1});
    grid.push_back('{0,   1, 12'hFFF, 1'b1, 1'b1, 1'b1});
    grid.push_back('{1,   1, 12'h000, 1'b1, 1'b1, 1'b1});
    grid.push_back('{32,  1, 12'hFFF, 1'b1, 1'b1, 1'b1});
    grid.push_back('{33,  1, 12'h000, 1'b1, 1'b1, 1'b1});
    grid.push_back('{639, 1, 12'h000, 1'b1, 1'b1, 1'b1});
    grid.push_back('{64,  2, 12'hFFF, 1'b1, 1'b1, 1'b1});
    grid.push_back('{100, 2, 12'h000, 1'b1, 1'b1, 1'b1});
    grid.push_back('{639, 3, 12'h000, 1'b1, 1'b1, 1'b1});
    grid.push_back('{96,  4, 12'h000, 1'b0, 1'b1, 1'b1});

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset hs_n", 32'(vga_hs_n), 32'd1);
    chk("reset vs_n", 32'(vga_vs_n), 32'd1);
    chk("reset rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    chk("reset blank_n", 32'(blank_n), 32'd0);
    chk("reset frame_start", 32'(frame_start), 32'd0);

    // Enable: first output (0,0) with frame_start CLK_DIV clocks later
    reset_n = 1'b1;
    ctrl    = 2'b01;
    @(negedge clk);
    chk("enable fs early", 32'(frame_start), 32'd0);
    @(negedge clk);
    chk("enable fs at CLK_DIV", 32'(frame_start), 32'd1);
    pos = 0;
    check_vec("bars", bars[0]);
    @(negedge clk);
    pos++;
    chk("frame_start width", 32'(frame_start), 32'd0);
    for (int i = 1; i < bars.size(); i++) check_vec("bars", bars[i]);

    // Sync periods and pulse widths in system clocks
    measure(1'b0, 4000, lo, per);
    chk("hs_n low clks", 32'(lo), 32'd192);
    chk("hs_n period clks", 32'(per), 32'd1600);
    measure(1'b1, 30000, lo, per);
    chk("vs_n low clks", 32'(lo), 32'(V_SYNC * 1600));
    chk("vs_n period clks", 32'(per), 32'((V_ACTIVE + V_FP + V_SYNC + V_BP) * 1600));

    // Mid-frame pattern change: bars continue until the next frame
    wait_fs();
    goto(0, 1);
    ctrl = 2'b11;
    check_vec("after change", '{100, 2, 12'hFF0, 1'b1, 1'b1, 1'b1});
    check_vec("after change", '{400, 3, 12'hF00, 1'b1, 1'b1, 1'b1});
    wait_fs();
    for (int i = 0; i < grid.size(); i++) check_vec("grid", grid[i]);

    // Mid-frame disable during both syncs, then re-enable
    check_vec("pre-disable", '{700, 5, 12'h000, 1'b0, 1'b0, 1'b0});
    ctrl = 2'b10;
    @(negedge clk);
    chk("disable hs_n", 32'(vga_hs_n), 32'd1);
    chk("disable vs_n", 32'(vga_vs_n), 32'd1);
    chk("disable blank_n", 32'(blank_n), 32'd0);
    chk("disable rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    repeat (7) @(negedge clk);
    chk("idle frame_start", 32'(frame_start), 32'd0);
    ctrl = 2'b11;
    @(negedge clk);
    chk("re-enable fs early", 32'(frame_start), 32'd0);
    @(negedge clk);
    chk("re-enable fs at CLK_DIV", 32'(frame_start), 32'd1);
    pos = 0;
    check_vec("re-enable", '{0, 0, 12'hFFF, 1'b1, 1'b1, 1'b1});
    check_vec("re-enable", '{64, 1, 12'hFFF, 1'b1, 1'b1, 1'b1});

    // Asynchronous reset mid-frame, checked before the next clock edge
    #1 reset_n = 1'b0;
    #1;
    chk("async reset hs_n", 32'(vga_hs_n), 32'd1);
    chk("async reset vs_n", 32'(vga_vs_n), 32'd1);
    chk("async reset rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    chk("async reset blank_n", 32'(blank_n), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
